mem_align_unit: RTL
===================

# mem_align_unit

Memory-stage alignment unit placed directly upstream of the data memory. It turns a byte-addressed load/store request from the MEM pipeline stage into word-aligned memory accesses with per-byte write enables and lane-shifted write data. It extracts and sign- or zero-extends load data from the returned word. Accesses that cross a 32-bit word boundary are split into two consecutive memory cycles, and the pipeline is stalled for one cycle while this happens.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: load/store request present this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_type` in 3: access type, encoded as in `ctrl_encode_def.v`: `dm_word`=0, `dm_halfword`=1, `dm_halfword_unsigned`=2, `dm_byte`=3, `dm_byte_unsigned`=4. Codes 5–7 are treated as `dm_word`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `mem_addr` out 32: word-aligned address to memory; bits [1:0] are always 0.
- `mem_we` out 4: byte-lane write enables; lane i = bits [8i+7:8i].
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: combinational read data from memory for `mem_addr`.
- `rsp_valid` out 1: the access completes this cycle.
- `rsp_rdata` out 32: extended load data; 0 for stores.
- `stall` out 1: hold the MEM stage, because the request is not yet complete.
- `split_cnt` out 16: count of split accesses, wraps modulo 2^16.

## Operation
**Address decomposition**
- A0 = {req_addr[31:2], 2'b00}.
- o = req_addr[1:0].
- n = 4, 2 or 1 bytes for word, halfword or byte types respectively.
- A1 = A0 + 4, wrapping modulo 2^32.

**Single access (o + n ≤ 4)**
- `mem_addr` = A0.
- `mem_we` = ((1<<n) − 1) << o when `req_we`, else 0.
- `mem_wdata` = `req_wdata` << 8o.
- Load result = `mem_rdata` >> 8o, truncated to n bytes, then extended according to `req_type`.
- `rsp_valid` = 1 and `stall` = 0 in the same cycle.

**Split access (o + n > 4)**
- FSM states: IDLE and SECOND.
- IDLE, first half:
  - `mem_addr` = A0, covering lanes o..3.
  - `mem_we` = 4'b1111 << o for stores, else 0.
  - `mem_wdata` = `req_wdata` << 8o.
  - `stall` = 1, `rsp_valid` = 0.
  - At the clock edge: `hold` ← `mem_rdata`[31:8o], `split_cnt`++, next state SECOND.
- SECOND, second half:
  - `mem_addr` = A1, covering lanes 0..k−1, where k = o + n − 4.
  - `mem_we` = (1<<k) − 1 for stores, else 0.
  - `mem_wdata` = `req_wdata` >> 8(4 − o).
  - Load bytes = {`mem_rdata`[8k−1:0], `hold`}, truncated to n bytes, then extended.
  - `rsp_valid` = 1, `stall` = 0, next state IDLE.
- SECOND with `req_valid` = 0: abort. `mem_we` = 0, `rsp_valid` = 0, `stall` = 0, next state IDLE. The first-half store bytes stay written.
- The requester holds `req_*` stable while `stall` = 1. Changes to `req_*` in SECOND other than dropping `req_valid` are undefined.

**Idle and reset behaviour**
- When `req_valid` = 0 in IDLE: `mem_we` = 0, `rsp_valid` = 0, `stall` = 0, `mem_addr` = A0.
- Reset clears state to IDLE, `hold` to 0 and `split_cnt` to 0.
- While `rst` = 1, all outputs are forced to 0.

## Timing
- Aligned or single access: 0-cycle latency; the response is combinational from `req_*` and `mem_rdata`.
- Split access: 2 cycles, with `stall` high in cycle 1 only and `rsp_valid` in cycle 2.
- Store writes take effect at the rising edge that ends the cycle in which the lanes are enabled. A split store therefore modifies memory over two edges.
- A request may be presented in the cycle immediately after a split completes. Back-to-back throughput is 1 per cycle (aligned) or 1 per 2 cycles (split).
- Reset asserted in SECOND: the state returns to IDLE asynchronously and no second-half write occurs.
- A1 wrap: a request at 0xFFFFFFFE of type `dm_word` issues its second access at 0x00000000.

## Test plan
Memory preloaded with word 0x44332211 at 0x100 and word 0x88776655 at 0x104.

- `dm_word` load at 0x102:
  - Cycle 1: `mem_addr`=0x100, `stall`=1.
  - Cycle 2: `mem_addr`=0x104, `rsp_rdata`=0x66554433, `split_cnt`=1.
- `dm_byte` load at 0x107 → `rsp_rdata`=0xFFFFFF88, no stall. `dm_byte_unsigned` load at 0x107 → 0x00000088. `dm_halfword` load at 0x103 → 0x00005544, split into 2 cycles.
- `dm_word` store of 0xAABBCCDD at 0x101:
  - Cycle 1: `mem_we`=4'b1110, `mem_wdata`[31:8]=0xBBCCDD.
  - Cycle 2: `mem_addr`=0x104, `mem_we`=4'b0001, `mem_wdata`[7:0]=0xAA.
  - Memory afterwards: word 0xBBCCDD11 at 0x100 and word 0x887766AA at 0x104.
- `dm_halfword` store of 0x1234 at 0x102 → single cycle, `mem_we`=4'b1100, `mem_wdata`=0x12340000, `stall`=0.
- `dm_word` load at 0xFFFFFFFE → second access `mem_addr`=0x00000000. Assert `rst` during SECOND of a split store → outputs go to 0 immediately, no second-half write, state IDLE, `split_cnt`=0.

Source files
------------

// File: rtl/mem_align_unit.sv
// mem_align_unit: byte-addressed load/store aligner in front of a word-wide data memory.
// Accesses that cross a word boundary are split over two cycles with a one-cycle stall.
module mem_align_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic [15:0] split_cnt
);
    typedef enum logic {IDLE, SECOND} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_hold;
    logic [15:0] r_split_cnt;

    logic [31:0] w_a0, w_a1;
    logic [1:0]  w_o, w_k;
    logic [2:0]  w_n, w_end;
    logic [3:0]  w_mask;
    logic [4:0]  w_lsh;
    logic [5:0]  w_rsh;
    logic        w_split;

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] d);
        return t == 3'd1 ? {{16{d[15]}}, d[15:0]} :
               t == 3'd2 ? {16'b0, d[15:0]} :
               t == 3'd3 ? {{24{d[7]}}, d[7:0]} :
               t == 3'd4 ? {24'b0, d[7:0]} : d;
    endfunction

    assign w_a0    = {req_addr[31:2], 2'b00};
    assign w_a1    = w_a0 + 32'd4;
    assign w_o     = req_addr[1:0];
    assign w_n     = (req_type == 3'd1 || req_type == 3'd2) ? 3'd2 :
                     (req_type == 3'd3 || req_type == 3'd4) ? 3'd1 : 3'd4;
    assign w_mask  = w_n == 3'd4 ? 4'hF : w_n == 3'd2 ? 4'h3 : 4'h1;
    assign w_end   = {1'b0, w_o} + w_n;
    assign w_split = w_end > 3'd4;
    // Bytes spilling into the next word: w_end is 5..7 when split, so its low bits are k.
    assign w_k     = w_end[1:0];
    assign w_lsh   = {w_o, 3'b000};
    assign w_rsh   = 6'd32 - {1'b0, w_lsh};
    assign split_cnt = r_split_cnt;

    always_comb begin
        mem_addr  = w_a0;
        mem_we    = 4'b0;
        mem_wdata = req_wdata << w_lsh;
        rsp_valid = 1'b0;
        rsp_rdata = 32'b0;
        stall     = 1'b0;
        w_next    = IDLE;
        if (r_state == SECOND) begin
            mem_addr  = w_a1;
            mem_wdata = req_wdata >> w_rsh;
            if (req_valid) begin
                mem_we    = req_we ? (4'b1 << w_k) - 4'd1 : 4'b0;
                rsp_valid = 1'b1;
                rsp_rdata = req_we ? 32'b0 : extend(req_type, r_hold | (mem_rdata << w_rsh));
            end
        end else if (req_valid) begin
            if (w_split) begin
                mem_we = req_we ? 4'hF << w_o : 4'b0;
                stall  = 1'b1;
                w_next = SECOND;
            end else begin
                mem_we    = req_we ? w_mask << w_o : 4'b0;
                rsp_valid = 1'b1;
                rsp_rdata = req_we ? 32'b0 : extend(req_type, mem_rdata >> w_lsh);
            end
        end
        if (rst) begin
            mem_addr  = 32'b0;
            mem_we    = 4'b0;
            mem_wdata = 32'b0;
            rsp_valid = 1'b0;
            rsp_rdata = 32'b0;
            stall     = 1'b0;
            w_next    = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= 32'b0;
            r_split_cnt <= 16'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid && w_split) begin
                r_hold      <= mem_rdata >> w_lsh;
                r_split_cnt <= r_split_cnt + 16'd1;
            end
        end
    end
endmodule
